stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Top-level sequencer for the stopwatch counter datapath. It conditions the three raw push-buttons (start/stop, lap, clear) and runs a four-state control machine.
- It drives the datapath's count-enable tick, clear and display-hold controls.
- It supersedes the bare start/stop toggle with debounced inputs, lap freeze and a gated prescaler.

Parameters:
- DIV, 1_000_000, clk cycles per count tick (100 MHz -> 10 ms). Minimum 2.
- DB_CYCLES, 500_000, consecutive stable synchronized cycles required to accept a button level change. Minimum 1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- ststop  input  1  raw start/stop button, asynchronous, active-high.
- lap  input  1  raw lap button, asynchronous, active-high.
- clear  input  1  raw clear button, asynchronous, active-high.
- run  output  1  high while the stopwatch is counting (states RUN, LAP).
- tick  output  1  one-cycle count-enable pulse to the BCD counter chain.
- clr  output  1  one-cycle synchronous clear pulse to the counter chain.
- disp_hold  output  1  high while the display must show the latched lap value.
- lap_strobe  output  1  one-cycle pulse; the datapath captures the lap value on it.

Behaviour:
- Reset (reset=1 at a clk edge) forces the following, and takes priority over everything, including mid-debounce and mid-prescale:
  - state=IDLE.
  - run=tick=clr=disp_hold=lap_strobe=0.
  - Prescaler=0.
  - Synchronizer, debounce counters and debounced levels=0.
- All outputs are registered; no combinational path from input to output.

Input conditioning (per button, identical):
- 2-flop synchronizer.
- Debounce counter resets whenever the synchronized value equals the debounced level. When they differ, it increments.
- When the counter reaches DB_CYCLES-1 with the value still differing, the debounced level takes the synchronized value and the counter resets.
- Event = rising edge of the debounced level, a one-cycle internal pulse. Release produces no event.
- A glitch shorter than DB_CYCLES cycles produces no event.
- Holding a button produces exactly one event.

Control FSM (states IDLE, RUN, LAP, STOP); event priority when simultaneous: clear > ststop > lap:
- IDLE: run=0, disp_hold=0.
  - ststop event -> RUN.
  - clear event -> stay IDLE, clr pulse.
  - lap event ignored.
- RUN: run=1, disp_hold=0.
  - ststop event -> STOP.
  - lap event -> LAP; lap_strobe pulses in the same cycle disp_hold rises.
  - clear event ignored.
- LAP: run=1, disp_hold=1; counting continues underneath.
  - lap event -> RUN (release).
  - ststop event -> STOP with disp_hold=0.
  - clear event ignored.
- STOP: run=0, disp_hold=0.
  - ststop event -> RUN (resume, count preserved).
  - clear event -> IDLE with clr pulse.
  - lap event ignored.
- Illegal state encoding -> IDLE, outputs 0.
- Latency: the output change (run/disp_hold/clr/lap_strobe) is registered on the clk edge after the event pulse. Raw press to output = 2 + DB_CYCLES + 1 cycles, ±1.

Prescaler:
- Counts 0..DIV-1 only while run=1.
- tick=1 for exactly one cycle when the prescaler wraps from DIV-1 to 0.
- First tick arrives DIV cycles after run rises.
- Holds its value while run=0, so partial intervals carry across stop/resume.
- Zeroed in the same cycle clr asserts; tick is never 1 while clr=1 or run=0.
- tick and lap_strobe may coincide.

Test Plan (DIV=4, DB_CYCLES=3):
1. Reset then ststop high for 10 cycles:
   - run=1 at cycle 2+3+1=6 (±1) after press, stays 1 after release (no second event).
   - tick on every 4th cycle after run rose: first at run+4.
2. Running, ststop press:
   - run->0, ticks stop.
   - Press ststop again 20 cycles later: run->1, next tick arrives after the remaining prescale count (no restart at 0).
3. RUN, lap press:
   - lap_strobe one pulse, disp_hold=1, ticks continue every 4 cycles.
   - Second lap press: disp_hold->0.
   - LAP then ststop: state STOP, disp_hold=0, run=0.
4. STOP, clear press:
   - clr one-cycle pulse, state IDLE, prescaler 0.
   - Next ststop: first tick exactly 4 cycles after run rises.
   - clear while RUN: no clr, run stays 1.
5. Glitches and simultaneous events:
   - ststop pulses 2 cycles wide (shorter than DB_CYCLES): no event, run stays 0.
   - In STOP, clear and ststop debounced in the same cycle: clear wins -> IDLE, clr=1, run=0.
6. Reset mid-operation:
   - Assert reset in LAP with prescaler=2 and a half-debounced lap press.
   - Next cycle all outputs 0, state IDLE; no spurious event after reset deasserts while the button is still held low.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: conditions the start/stop, lap and clear
// buttons, runs the IDLE/RUN/LAP/STOP machine and gates the count prescaler
// that feeds the BCD counter chain. Every output comes straight from a flop.
module stopwatch_ctrl #(
    parameter int DIV       = 1_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic ststop,
    input  logic lap,
    input  logic clear,
    output logic run,
    output logic tick,
    output logic clr,
    output logic disp_hold,
    output logic lap_strobe
);
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int PS_W = $clog2(DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    // Button lanes: 0 = clear, 1 = start/stop, 2 = lap.
    logic [2:0] btn_raw;
    logic [2:0] btn_evt;
    assign btn_raw = {lap, ststop, clear};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_q, sync2_q;
            logic            lvl_q, lvl_d;
            logic            evt_q, evt_d;
            logic [DB_W-1:0] cnt_q, cnt_d;

            // Debounce: count consecutive cycles the synchronized level disagrees
            // with the accepted level; accept it after DB_CYCLES of disagreement.
            always_comb begin
                cnt_d = '0;
                lvl_d = lvl_q;
                evt_d = 1'b0;
                if (sync2_q != lvl_q) begin
                    if (cnt_q == DB_LAST) begin
                        lvl_d = sync2_q;
                        evt_d = sync2_q;   // only a press (rising level) is an event
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
            end

            // Synchronizer, debounce state and the registered event pulse.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    cnt_q   <= '0;
                    lvl_q   <= 1'b0;
                    evt_q   <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    cnt_q   <= cnt_d;
                    lvl_q   <= lvl_d;
                    evt_q   <= evt_d;
                end
            end

            assign btn_evt[gi] = evt_q;
        end
    endgenerate

    logic ev_clear, ev_ststop, ev_lap;
    assign ev_clear  = btn_evt[0];
    assign ev_ststop = btn_evt[1];
    assign ev_lap    = btn_evt[2];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAP  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            run_q, run_d;
    logic            hold_q, hold_d;
    logic            clr_q, clr_d;
    logic            strobe_q, strobe_d;
    logic            tick_q, tick_d;
    logic [PS_W-1:0] ps_q, ps_d;

    // Next state and pulse outputs; clear beats start/stop beats lap.
    always_comb begin
        state_d  = state_q;
        clr_d    = 1'b0;
        strobe_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev_clear)       clr_d   = 1'b1;
                else if (ev_ststop) state_d = S_RUN;
            end
            S_RUN: begin
                if (ev_ststop) begin
                    state_d = S_STOP;
                end else if (ev_lap) begin
                    state_d  = S_LAP;
                    strobe_d = 1'b1;
                end
            end
            S_LAP: begin
                if (ev_ststop)   state_d = S_STOP;
                else if (ev_lap) state_d = S_RUN;
            end
            S_STOP: begin
                if (ev_clear) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end else if (ev_ststop) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        run_d  = (state_d == S_RUN) || (state_d == S_LAP);
        hold_d = (state_d == S_LAP);
    end

    // Prescaler only advances across edges where run stays high, so a stop
    // freezes the partial interval and no tick can land while run is low.
    always_comb begin
        ps_d   = ps_q;
        tick_d = 1'b0;
        if (clr_d) begin
            ps_d = '0;
        end else if (run_q && run_d) begin
            if (ps_q == PS_LAST) begin
                ps_d   = '0;
                tick_d = 1'b1;
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    // State, prescaler and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            run_q    <= 1'b0;
            hold_q   <= 1'b0;
            clr_q    <= 1'b0;
            strobe_q <= 1'b0;
            tick_q   <= 1'b0;
            ps_q     <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            hold_q   <= hold_d;
            clr_q    <= clr_d;
            strobe_q <= strobe_d;
            tick_q   <= tick_d;
            ps_q     <= ps_d;
        end
    end

    assign run        = run_q;
    assign tick       = tick_q;
    assign clr        = clr_q;
    assign disp_hold  = hold_q;
    assign lap_strobe = strobe_q;
endmodule
